icb_arb_2m1s: RTL

- Two-master to one-slave ICB arbiter with outstanding-transaction tracking. It sits between the core ports (m0 = LSU/data, m1 = IFU/debug) and the slave-decode bus bridge.
- Arbitration is fixed-priority (m0 first) with a starvation guard for m1.
- Each accepted command has exactly one response, reads and writes alike. Responses are routed back through an in-order master-ID FIFO, so several transactions can be outstanding at once.

---
 rtl/icb_arb_2m1s_pkg.sv | 20 ++
 rtl/icb_arb_2m1s_id_fifo.sv | 43 ++++
 rtl/icb_arb_2m1s.sv | 132 +++++++++++++
 3 files changed

// File: rtl/icb_arb_2m1s_pkg.sv
// icb_arb_2m1s_pkg: bus-width defines and shared types for the 2-master ICB arbiter.
// Also carries the defines.v bus macros (MemAddrBus, MemBus, IcbIdW, IcbArbOutsDepth).
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif
`ifndef IcbIdW
`define IcbIdW 1
`endif
`ifndef IcbArbOutsDepth
`define IcbArbOutsDepth 4
`endif

package icb_arb_2m1s_pkg;
   typedef logic [`IcbIdW-1:0] icb_id_t;
   localparam icb_id_t ID_M0 = icb_id_t'(0);
   localparam icb_id_t ID_M1 = icb_id_t'(1);
endpackage

// File: rtl/icb_arb_2m1s_id_fifo.sv
// icb_id_fifo: in-order FIFO of master IDs for outstanding ICB commands.
import icb_arb_2m1s_pkg::*;

module icb_id_fifo #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  icb_id_t       push_id,
   input  logic          pop,
   output icb_id_t       head_id,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0] wptr, rptr;
   icb_id_t       mem [DEPTH];
   logic          push_en, pop_en;
   assign full    = count == CW'(DEPTH);
   assign empty   = count == '0;
   assign push_en = push & ~full;
   assign pop_en  = pop & ~empty;
   assign head_id = mem[rptr];
   // storage only; contents are meaningless while count is zero
   always_ff @(posedge clk) begin
      if (push_en) mem[wptr] <= push_id;
   end
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_en) wptr <= wptr + 1'b1;
         if (pop_en) rptr <= rptr + 1'b1;
         count <= count + CW'(push_en) - CW'(pop_en);
      end
   end
endmodule

// File: rtl/icb_arb_2m1s.sv
// icb_arb_2m1s: 2-master/1-slave ICB arbiter with outstanding-ID tracking.
// Optional ICB_ARB_RR_EN: round-robin grant instead of fixed priority + starvation guard.
import icb_arb_2m1s_pkg::*;

module icb_arb_2m1s #(
   parameter int OUTS_DEPTH = `IcbArbOutsDepth,
   parameter int STARVE_MAX = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               m0_icb_cmd_valid,
   output logic               m0_icb_cmd_ready,
   input  logic [`MemAddrBus] m0_icb_cmd_addr,
   input  logic               m0_icb_cmd_read,
   input  logic [`MemBus]     m0_icb_cmd_wdata,
   input  logic [3:0]         m0_icb_cmd_wmask,
   output logic               m0_icb_rsp_valid,
   input  logic               m0_icb_rsp_ready,
   output logic               m0_icb_rsp_err,
   output logic [`MemBus]     m0_icb_rsp_rdata,
   input  logic               m1_icb_cmd_valid,
   output logic               m1_icb_cmd_ready,
   input  logic [`MemAddrBus] m1_icb_cmd_addr,
   input  logic               m1_icb_cmd_read,
   input  logic [`MemBus]     m1_icb_cmd_wdata,
   input  logic [3:0]         m1_icb_cmd_wmask,
   output logic               m1_icb_rsp_valid,
   input  logic               m1_icb_rsp_ready,
   output logic               m1_icb_rsp_err,
   output logic [`MemBus]     m1_icb_rsp_rdata,
   output logic               s_icb_cmd_valid,
   input  logic               s_icb_cmd_ready,
   output logic [`MemAddrBus] s_icb_cmd_addr,
   output logic               s_icb_cmd_read,
   output logic [`MemBus]     s_icb_cmd_wdata,
   output logic [3:0]         s_icb_cmd_wmask,
   input  logic               s_icb_rsp_valid,
   output logic               s_icb_rsp_ready,
   input  logic               s_icb_rsp_err,
   input  logic [`MemBus]     s_icb_rsp_rdata,
   output logic               arb_err
);
   localparam int CW = $clog2(OUTS_DEPTH) + 1;
   icb_id_t       gnt, gnt_pre, lock_id, head;
   logic          lock, gnt_vld, room, has_out, cmd_hs, rsp_hs, orphan;
   logic [CW-1:0] count;
   logic          full, empty;

`ifdef ICB_ARB_RR_EN
   icb_id_t last_gnt;
   // priority goes to whichever master was not granted last
   always_comb begin
      gnt_pre = (last_gnt == ID_M0) ? (m1_icb_cmd_valid ? ID_M1 : ID_M0)
                                    : (m0_icb_cmd_valid ? ID_M0 : (m1_icb_cmd_valid ? ID_M1 : ID_M0));
   end
   // remember the last granted master; reset value lets m0 win first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_gnt <= ID_M1;
      else if (cmd_hs) last_gnt <= gnt;
   end
`else
   logic [7:0] wait_cnt;
   logic       starved;
   assign starved = wait_cnt == 8'(STARVE_MAX);
   // fixed priority to m0 unless m1 has waited STARVE_MAX cycles
   always_comb begin
      gnt_pre = (starved && m1_icb_cmd_valid) ? ID_M1
              : (m0_icb_cmd_valid ? ID_M0 : (m1_icb_cmd_valid ? ID_M1 : ID_M0));
   end
   // count consecutive cycles m1 is waiting, saturating at STARVE_MAX
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wait_cnt <= '0;
      else if (!m1_icb_cmd_valid || m1_icb_cmd_ready) wait_cnt <= '0;
      else if (!starved) wait_cnt <= wait_cnt + 8'd1;
   end
`endif

   assign gnt     = lock ? lock_id : gnt_pre;
   assign gnt_vld = (gnt == ID_M1) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign room    = ~full;
   assign has_out = count != '0;
   assign orphan  = s_icb_rsp_valid & empty;

   assign s_icb_cmd_valid  = gnt_vld & room;
   assign s_icb_cmd_addr   = (gnt == ID_M1) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign s_icb_cmd_read   = (gnt == ID_M1) ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign s_icb_cmd_wdata  = (gnt == ID_M1) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign s_icb_cmd_wmask  = (gnt == ID_M1) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
   assign m0_icb_cmd_ready = (gnt == ID_M0) & gnt_vld & s_icb_cmd_ready & room;
   assign m1_icb_cmd_ready = (gnt == ID_M1) & gnt_vld & s_icb_cmd_ready & room;
   assign cmd_hs           = s_icb_cmd_valid & s_icb_cmd_ready;

   assign m0_icb_rsp_valid = s_icb_rsp_valid & has_out & (head == ID_M0);
   assign m1_icb_rsp_valid = s_icb_rsp_valid & has_out & (head == ID_M1);
   assign m0_icb_rsp_err   = s_icb_rsp_err & m0_icb_rsp_valid;
   assign m1_icb_rsp_err   = s_icb_rsp_err & m1_icb_rsp_valid;
   assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
   assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
   assign s_icb_rsp_ready  = ~has_out | ((head == ID_M1) ? m1_icb_rsp_ready : m0_icb_rsp_ready);
   assign rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready & has_out;

   // hold the grant on a stalled command so the slave sees stable signals
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock    <= 1'b0;
         lock_id <= ID_M0;
      end else if (cmd_hs) begin
         lock    <= 1'b0;
      end else if (s_icb_cmd_valid) begin
         lock    <= 1'b1;
         lock_id <= gnt;
      end
   end

   // sticky flag for responses arriving with nothing outstanding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) arb_err <= 1'b0;
      else if (orphan) arb_err <= 1'b1;
   end

   icb_id_fifo #(.DEPTH(OUTS_DEPTH), .CW(CW)) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (cmd_hs),
      .push_id (gnt),
      .pop     (rsp_hs),
      .head_id (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );
endmodule
